pipe_adder: RTL

Parametrised, pipelined N-bit adder/subtractor with valid/ready flow control. It is the multi-stage successor of the team's 4-bit ripple adder. The operand is split into CHUNK-bit slices, and each slice is added in its own pipeline stage, with the carry registered between stages, so WIDTH scales without lengthening the critical path. It sits between operand producers and the datapath's result consumers, and it tolerates backpressure.

---
 rtl/pipe_adder_pkg.sv | 28 ++
 rtl/pipe_adder_if.sv | 30 +++
 rtl/adder_chunk.sv | 38 +++
 rtl/full_adder.sv | 16 +
 rtl/pipe_adder.sv | 132 +++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: stage count and configuration check.
package pipe_adder_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_CHUNK = 8;

   // Number of pipeline stages. A zero CHUNK or a WIDTH narrower than CHUNK
   // falls back to one stage so that elaboration can still report the error.
   function automatic int pipe_stages(input int unsigned width, input int unsigned chunk);
      int unsigned n;
      if (chunk == 0) begin
         n = 1;
      end else begin
         n = width / chunk;
         if (n == 0) n = 1;
      end
      return int'(n);
   endfunction

   // Legal configuration: CHUNK >= 1, WIDTH a nonzero multiple of CHUNK.
   function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
      if (chunk < 1)           return 1'b0;
      if (width < chunk)       return 1'b0;
      if (width % chunk != 0)  return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// master: operand producer and result consumer; slave: the adder.
interface pipe_adder_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple adder. Besides sum and carry-out it exposes the carry into
// its MSB, which the last pipeline stage needs for signed overflow.
module adder_chunk #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   // Each bit keeps its own carry nets so the chain is a set of distinct
   // signals rather than one self-referencing vector.
   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      logic ci;
      logic co;

      if (i == 0) begin : g_first
         assign ci = c_i;
      end else begin : g_next
         assign ci = g_bit[i-1].co;
      end

      full_adder u_fa (
         .a_i (a_i[i]),
         .b_i (b_i[i]),
         .c_i (ci),
         .s_o (sum_o[i]),
         .c_o (co)
      );
   end

   assign cout_o = g_bit[CHUNK-1].co;
   assign cmsb_o = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of every chunk ripple.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic p;

   assign p   = a_i ^ b_i;
   assign s_o = p ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Stage k adds slice k of A and B'
// using the carry registered by stage k-1; operand slices still to be added
// and already-finished sum slices travel along, so a result leaves aligned.
// The whole pipe advances together: a stalled output freezes every stage.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_CHUNK
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_adder_if.slave bus
);

   localparam int STAGES = pipe_stages(WIDTH, CHUNK);

   if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
      $error("pipe_adder: WIDTH must be a nonzero multiple of CHUNK (CHUNK >= 1)");
   end

   // Stage output registers; index STAGES-1 is the output register.
   logic             valid_q [STAGES];
   logic             carry_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] s_q     [STAGES];
   logic             ovf_q;

   // Stage inputs: stage 0 from the bus, stage k from stage k-1 registers.
   logic             st_v    [STAGES];
   logic             st_c    [STAGES];
   logic [WIDTH-1:0] st_a    [STAGES];
   logic [WIDTH-1:0] st_b    [STAGES];
   logic [WIDTH-1:0] st_s    [STAGES];

   // Per-stage chunk adder results and next-state sums.
   logic [CHUNK-1:0] ch_sum  [STAGES];
   logic             ch_co   [STAGES];
   logic             ch_cmsb [STAGES];
   logic [WIDTH-1:0] s_d     [STAGES];
   logic             ovf_d;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Advance whenever the output register is empty or being drained.
   assign adv          = !valid_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   // Subtraction is A + ~B + 1; the external carry-in is ignored then.
   assign b_eff   = bus.sub ? ~bus.b : bus.b;
   assign cin_eff = bus.sub | bus.cin;

   // Route each stage's inputs: bus for stage 0, previous registers after.
   always_comb begin
      st_v[0] = bus.in_valid & adv;
      st_c[0] = cin_eff;
      st_a[0] = bus.a;
      st_b[0] = b_eff;
      st_s[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         st_v[k] = valid_q[k-1];
         st_c[k] = carry_q[k-1];
         st_a[k] = a_q[k-1];
         st_b[k] = b_q[k-1];
         st_s[k] = s_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a_i    (st_a[k][k*CHUNK +: CHUNK]),
         .b_i    (st_b[k][k*CHUNK +: CHUNK]),
         .c_i    (st_c[k]),
         .sum_o  (ch_sum[k]),
         .cout_o (ch_co[k]),
         .cmsb_o (ch_cmsb[k])
      );
   end

   // Drop each stage's freshly computed slice into the travelling sum word.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         s_d[k] = st_s[k];
         s_d[k][k*CHUNK +: CHUNK] = ch_sum[k];
      end
      ovf_d = ch_cmsb[STAGES-1] ^ ch_co[STAGES-1];
   end

   // Pipeline registers: reset clears everything, otherwise all move on adv.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            s_q[k]     <= '0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= st_v[k];
            carry_q[k] <= ch_co[k];
            a_q[k]     <= st_a[k];
            b_q[k]     <= st_b[k];
            s_q[k]     <= s_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.sum       = s_q[STAGES-1];
   assign bus.cout      = carry_q[STAGES-1];
   assign bus.ovf       = ovf_q;

   // Operand copies in the last stage and MSB carries of inner chunks have no
   // consumer; fold them into a sink so the intent is explicit.
   logic unused_bits;
   always_comb begin
      unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1]};
      for (int k = 0; k < STAGES - 1; k++) begin
         unused_bits = unused_bits ^ ch_cmsb[k];
      end
   end

endmodule
